// File: rtl/store_narrow_unit.sv
// Store path for byte/halfword/word writes into word-organised memory.
// Narrow stores read the containing word, merge the new lane, then write it back.
module store_narrow_unit #(
    parameter int ADDR_W = 30
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        size,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              misaligned,
    output logic              narrow_ovf,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [31:0]       mem_rdata,
    output logic              mem_we,
    output logic [31:0]       mem_wdata
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        MRG,
        WR,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic              is_byte_q, is_byte_d;
    logic [1:0]        lane_q, lane_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              mem_re_q, mem_re_d;
    logic              mem_we_q, mem_we_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              mis_q, mis_d;
    logic              ovf_q, ovf_d;

    logic              mis_c;
    logic              ovf_c;
    logic [31:0]       merged_c;

    // Overflow is the inverse of sign extension: every bit above the target sign bit must match it.
    always_comb begin
        mis_c = (size == 2'b11)
              | ((size == 2'b01) & addr[0])
              | ((size == 2'b10) & (addr[1:0] != 2'b00));
        ovf_c = 1'b0;
        if (size == 2'b00) begin
            ovf_c = !((&wdata[31:7]) | ~(|wdata[31:7]));
        end else if (size == 2'b01) begin
            ovf_c = !((&wdata[31:15]) | ~(|wdata[31:15]));
        end
    end

    always_comb begin
        merged_c = mem_rdata;
        if (is_byte_q) begin
            merged_c[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged_c[{lane_q[1], 4'b0000} +: 16] = wdata_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        is_byte_d   = is_byte_q;
        lane_d      = lane_q;
        wdata_d     = wdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mis_d       = mis_q;
        ovf_d       = ovf_q;
        mem_re_d    = 1'b0;
        mem_we_d    = 1'b0;
        done_d      = 1'b0;
        busy_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    is_byte_d  = (size == 2'b00);
                    lane_d     = addr[1:0];
                    wdata_d    = wdata[15:0];
                    mem_addr_d = addr[ADDR_W+1:2];
                    mis_d      = mis_c;
                    ovf_d      = mis_c ? 1'b0 : ovf_c;
                    busy_d     = 1'b1;
                    if (mis_c) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (size == 2'b10) begin
                        state_d     = WR;
                        mem_we_d    = 1'b1;
                        mem_wdata_d = wdata;
                    end else begin
                        state_d  = RD;
                        mem_re_d = 1'b1;
                    end
                end
            end
            RD: begin
                state_d = MRG;
                busy_d  = 1'b1;
            end
            MRG: begin
                state_d     = WR;
                mem_we_d    = 1'b1;
                mem_wdata_d = merged_c;
                busy_d      = 1'b1;
            end
            WR: begin
                state_d = DONE;
                done_d  = 1'b1;
                busy_d  = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Every output comes straight from a flop, loaded with the value for the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            is_byte_q   <= 1'b0;
            lane_q      <= 2'b00;
            wdata_q     <= 16'h0000;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0000_0000;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            mis_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            is_byte_q   <= is_byte_d;
            lane_q      <= lane_d;
            wdata_q     <= wdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            mis_q       <= mis_d;
            ovf_q       <= ovf_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign misaligned = mis_q;
    assign narrow_ovf = ovf_q;
    assign mem_addr   = mem_addr_q;
    assign mem_re     = mem_re_q;
    assign mem_we     = mem_we_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_store_narrow_unit.sv
// Bench for store_narrow_unit: a small word memory answers the DUT's port,
// and a scoreboard queue of expected transactions is checked at each done.
module tb_store_narrow_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        misaligned;
    logic        narrow_ovf;
    logic [29:0] mem_addr;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic        mem_we;
    logic [31:0] mem_wdata;

    typedef struct {
        int          reCyc;
        int          weCyc;
        int          doneCyc;
        logic [31:0] addrW;
        logic [31:0] data;
        logic        mis;
        logic        ovf;
    } exp_t;

    exp_t        expQ[$];
    logic [31:0] mem[16];
    int          vectors = 0;
    int          miscompares = 0;
    int          cycleCount = 0;
    int          startCyc = 0;
    int          weCount = 0;
    int          doneCount = 0;
    int          obsRe = -1;
    int          obsWe = -1;
    logic [31:0] obsReAddr = 0;
    logic [31:0] obsWeAddr = 0;
    logic [31:0] obsWeData = 0;

    store_narrow_unit #(.ADDR_W(30)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .size(size),
        .addr(addr),
        .wdata(wdata),
        .busy(busy),
        .done(done),
        .misaligned(misaligned),
        .narrow_ovf(narrow_ovf),
        .mem_addr(mem_addr),
        .mem_re(mem_re),
        .mem_rdata(mem_rdata),
        .mem_we(mem_we),
        .mem_wdata(mem_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Memory responder: read data appears the cycle after mem_re.
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_addr[3:0]];
        if (mem_we) mem[mem_addr[3:0]] = mem_wdata;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mergeModel(input logic [31:0] old, input logic [1:0] sz,
                                               input logic [1:0] a, input logic [31:0] wd);
        logic [31:0] r;
        r = old;
        if (sz == 2'b00) begin
            case (a)
                2'd0: r[7:0]   = wd[7:0];
                2'd1: r[15:8]  = wd[7:0];
                2'd2: r[23:16] = wd[7:0];
                default: r[31:24] = wd[7:0];
            endcase
        end else if (a[1]) begin
            r[31:16] = wd[15:0];
        end else begin
            r[15:0] = wd[15:0];
        end
        return r;
    endfunction

    // Scoreboard monitor: records memory strobes, pops an expectation at each done.
    always @(negedge clk) begin
        int   rel;
        exp_t e;
        if (!rst_n) begin
            obsRe = -1;
            obsWe = -1;
        end else begin
            rel = cycleCount - startCyc;
            if (mem_re && mem_we) checkOutput("re_we_exclusive", 32'd1, 32'd0);
            if (mem_re) begin
                obsRe = rel;
                obsReAddr = {2'b00, mem_addr};
            end
            if (mem_we) begin
                obsWe = rel;
                obsWeAddr = {2'b00, mem_addr};
                obsWeData = mem_wdata;
                weCount++;
            end
            if (expQ.size() != 0 && rel == 1) checkOutput("busy_cycle1", {31'd0, busy}, 32'd1);
            if (done) begin
                doneCount++;
                if (expQ.size() == 0) begin
                    checkOutput("spurious_done", 32'd1, 32'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("done_cycle", rel, e.doneCyc);
                    checkOutput("busy_at_done", {31'd0, busy}, 32'd1);
                    checkOutput("misaligned", {31'd0, misaligned}, {31'd0, e.mis});
                    checkOutput("narrow_ovf", {31'd0, narrow_ovf}, {31'd0, e.ovf});
                    checkOutput("re_cycle", obsRe, e.reCyc);
                    checkOutput("we_cycle", obsWe, e.weCyc);
                    if (e.reCyc >= 0) checkOutput("re_addr", obsReAddr, e.addrW);
                    if (e.weCyc >= 0) begin
                        checkOutput("we_addr", obsWeAddr, e.addrW);
                        checkOutput("we_data", obsWeData, e.data);
                    end
                end
                obsRe = -1;
                obsWe = -1;
            end
        end
    end

    // Drives one store from a negedge, pushes its expectation, waits for done (bounded).
    // A second start is pulsed at relative cycle extraAt when extraAt > 0.
    task automatic applyStimulus(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                                 input int extraAt);
        exp_t e;
        logic mis;
        bit   gotDone;
        mis = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        e.mis   = mis;
        e.addrW = {4'd0, a[31:4], a[3:2]} & 32'h3FFF_FFFF;
        e.ovf   = 1'b0;
        if (!mis && sz == 2'b00) e.ovf = ($signed(wd) < -128) || ($signed(wd) > 127);
        if (!mis && sz == 2'b01) e.ovf = ($signed(wd) < -32768) || ($signed(wd) > 32767);
        if (mis) begin
            e.reCyc = -1; e.weCyc = -1; e.doneCyc = 1; e.data = 32'd0;
        end else if (sz == 2'b10) begin
            e.reCyc = -1; e.weCyc = 1; e.doneCyc = 2; e.data = wd;
        end else begin
            e.reCyc = 1; e.weCyc = 3; e.doneCyc = 4;
            e.data = mergeModel(mem[a[5:2]], sz, a[1:0], wd);
        end
        expQ.push_back(e);
        start = 1'b1; size = sz; addr = a; wdata = wd;
        startCyc = cycleCount;
        gotDone = 0;
        for (int k = 1; k <= 12 && !gotDone; k++) begin
            @(negedge clk);
            if (k == extraAt) begin
                start = 1'b1; size = 2'b00; addr = 32'h0000_0010; wdata = 32'h0000_00EE;
            end else begin
                start = 1'b0;
            end
            if (done) gotDone = 1;
        end
        start = 1'b0;
        if (!gotDone) begin
            checkOutput("done_timeout", 32'd1, 32'd0);
            expQ.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int          wc;
        int          dc;
        logic [31:0] saved;
        rst_n = 1'b0; start = 1'b0; size = 2'b00; addr = 32'd0; wdata = 32'd0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_strobes", {30'd0, mem_re, mem_we}, 32'd0);
        checkOutput("reset_addr", {2'b00, mem_addr}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        mem[1] = 32'hAABBCCDD;
        applyStimulus(2'b00, 32'h5, 32'h0000_0011, 0);
        checkOutput("sb_mem_word", mem[1], 32'hAABB11DD);

        mem[1] = 32'hAABBCCDD;
        applyStimulus(2'b01, 32'h6, 32'hFFFF_8001, 0);
        checkOutput("sh_mem_word", mem[1], 32'h8001CCDD);

        mem[1] = 32'hAABBCCDD;
        applyStimulus(2'b00, 32'h4, 32'h0000_0180, 0);
        checkOutput("sb_ovf_mem_word", mem[1], 32'hAABBCC80);
        mem[0] = 32'h1111_2222;
        applyStimulus(2'b01, 32'h0, 32'h0001_8000, 0);
        checkOutput("sh_ovf_mem_word", mem[0], 32'h1111_8000);

        applyStimulus(2'b10, 32'h8, 32'h1234_5678, 0);
        checkOutput("sw_mem_word", mem[2], 32'h1234_5678);

        wc = weCount;
        applyStimulus(2'b01, 32'h3, 32'h0000_0001, 0);
        applyStimulus(2'b10, 32'h2, 32'h0000_0002, 0);
        applyStimulus(2'b11, 32'h0, 32'h0000_0003, 0);
        checkOutput("misaligned_no_write", weCount, wc);

        for (int i = 0; i < 8; i++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            sz = 2'($urandom_range(0, 1));
            a  = {26'd0, 4'($urandom_range(3, 6)), 2'($urandom_range(0, 3))};
            if (sz == 2'b01) a[0] = 1'b0;
            mem[a[5:2]] = $urandom;
            applyStimulus(sz, a, $urandom, 0);
        end

        // Abort a byte store in its merge cycle and confirm it never completes.
        mem[1] = 32'hAABBCCDD;
        wc = weCount; dc = doneCount; saved = mem[1];
        start = 1'b1; size = 2'b00; addr = 32'h4; wdata = 32'h0000_0180;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_flags", {30'd0, misaligned, narrow_ovf}, 32'd0);
        checkOutput("abort_strobes", {30'd0, mem_re, mem_we}, 32'd0);
        checkOutput("abort_wdata", mem_wdata, 32'd0);
        checkOutput("abort_addr", {2'b00, mem_addr}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("abort_no_write", weCount, wc);
        checkOutput("abort_no_done", doneCount, dc);
        checkOutput("abort_mem_word", mem[1], saved);

        applyStimulus(2'b00, 32'h7, 32'hFFFF_FF9A, 0);
        checkOutput("post_reset_mem_word", mem[1], 32'h9ABBCCDD);

        dc = doneCount;
        applyStimulus(2'b10, 32'hC, 32'hCAFE_F00D, 1);
        repeat (6) @(negedge clk);
        checkOutput("busy_start_ignored", doneCount - dc, 32'd1);
        checkOutput("busy_start_mem", mem[3], 32'hCAFE_F00D);

        checkOutput("pending_expectations", expQ.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
